// File: rtl/tinyalu_pkg.sv
// Shared types, widths and helpers for the tinyalu memory interface unit.
package tinyalu_pkg;

  localparam int MEM_ADDR_W = 14;
  localparam int MEM_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    WR_LO   = 3'd2,
    WR_HI   = 3'd3,
    DONE    = 3'd4,
    RELEASE = 3'd5
  } miu_state_t;

  // Byte address of the following location; 3FFF rolls over to 0000.
  function automatic logic [MEM_ADDR_W-1:0] addr_inc(input logic [MEM_ADDR_W-1:0] a);
    return a + MEM_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/mem_interface_unit_if.sv
// Byte-wide main-memory bus: the unit is the master, the memory is the slave.
interface mem_interface_unit_if;
  import tinyalu_pkg::*;

  logic                  mem_req;
  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [MEM_DATA_W-1:0] mem_wdata;
  logic                  mem_ack;
  logic [MEM_DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/miu_timeout.sv
// Per-access ack watchdog: counts cycles spent in an access state and flags the last allowed one.
module miu_timeout #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Count starts at 0 in the first cycle of a state, so this marks its TIMEOUT-th cycle.
  assign expired = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_interface_unit.sv
// Memory interface unit: turns level load/store requests into byte reads and
// two-byte little-endian writes on main memory, with an ack timeout.
module mem_interface_unit
  import tinyalu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  store,
  input  logic [MEM_ADDR_W-1:0] Addr,
  input  logic [15:0]           result,
  output logic [MEM_DATA_W-1:0] data,
  output logic                  mem_done,
  output logic                  mem_err,
  output logic                  busy,
  mem_interface_unit_if.master  mem
);

  miu_state_t            state_q, state_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [MEM_DATA_W-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  tmo_clr, tmo_en, tmo_expired;

  // NOTE: every next-state value gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (load || store) begin
          addr_d  = Addr;
          wdata_d = result;
          err_d   = 1'b0;
          state_d = load ? RD : WR_LO;   // load wins; a simultaneous store is dropped
        end
      end
      RD: begin
        if (mem.mem_ack) begin
          data_d  = mem.mem_rdata;
          state_d = DONE;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WR_LO: begin
        if (mem.mem_ack) begin
          state_d = WR_HI;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WR_HI: begin
        if (mem.mem_ack) begin
          state_d = DONE;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = RELEASE;
      // Holding off until both requests drop keeps a held level from re-executing.
      RELEASE: if (!load && !store) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Any state change restarts the watchdog, which covers entry to RD, WR_LO and WR_HI.
  assign tmo_clr = (state_d != state_q);
  assign tmo_en  = (state_q == RD) || (state_q == WR_LO) || (state_q == WR_HI);

  miu_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // Bus outputs depend on registered state only, so a reset drops mem_req immediately.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (state_q)
      RD: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = addr_q;
      end
      WR_LO: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = addr_q;
        mem.mem_wdata = wdata_q[7:0];
      end
      WR_HI: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = addr_inc(addr_q);
        mem.mem_wdata = wdata_q[15:8];
      end
      default: ;
    endcase
  end

  assign data     = data_q;
  assign mem_done = (state_q == DONE);
  assign mem_err  = (state_q == DONE) && err_q;
  assign busy     = (state_q != IDLE);

endmodule
